// File: rtl/key_debounce_onehot_if.sv
// Key debounce bus: raw keys and downstream handshake toward the encoder.
// The debouncer uses the slave modport; the key source / encoder side uses master.
interface key_debounce_onehot_if;
    logic [3:0] key_raw;
    logic [3:0] onehot;
    logic       valid;
    logic       ready;
    logic       multi_err;
    logic [3:0] stable;

    modport master (
        output key_raw, ready,
        input  onehot, valid, multi_err, stable
    );

    modport slave (
        input  key_raw, ready,
        output onehot, valid, multi_err, stable
    );
endinterface

// File: rtl/key_debounce_onehot.sv
// Four-key debouncer feeding a one-hot code to a 4-to-2 encoder with valid/ready.
// A press is accepted only if it is the sole key down; multi-key presses raise multi_err.
//
// state      | meaning
// S_IDLE     | waiting for a single fresh press
// S_HOLD     | event presented on onehot/valid until ready
// S_WAIT_REL | event consumed or rejected; wait for all keys released
module key_debounce_onehot #(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_debounce_onehot_if.slave  bus
);

    if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_param_err
        $error("key_debounce_onehot: DB_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] P_TC = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [3:0]       r_stable_q;
    logic [CNT_W-1:0] r_cnt [4];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_onehot;
    logic             r_valid;
    logic             r_multi_err;
    logic [3:0]       w_onehot_nxt;
    logic             w_valid_nxt;
    logic             w_multi_nxt;

    logic [3:0]       w_rise;
    logic [3:0]       w_others;
    logic [2:0]       w_nrise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable   <= '0;
            r_stable_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable_q <= r_stable;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == P_TC) begin
                    r_stable[i] <= ~r_stable[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise   = r_stable & ~r_stable_q;
    assign w_others = r_stable & ~w_rise;
    assign w_nrise  = 3'($countones(w_rise));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_onehot    <= '0;
            r_valid     <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_onehot    <= w_onehot_nxt;
            r_valid     <= w_valid_nxt;
            r_multi_err <= w_multi_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_onehot_nxt = r_onehot;
        w_valid_nxt  = r_valid;
        w_multi_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nrise == 3'd1 && w_others == 4'b0000) begin
                    w_onehot_nxt = w_rise;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_HOLD;
                end else if (w_nrise != 3'd0) begin
                    w_multi_nxt = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                end
            end
            S_HOLD: begin
                if (r_valid && bus.ready) begin
                    w_onehot_nxt = '0;
                    w_valid_nxt  = 1'b0;
                    w_state_nxt  = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (r_stable == 4'b0000) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_onehot_nxt = '0;
                w_valid_nxt  = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign bus.onehot    = r_onehot;
    assign bus.valid     = r_valid;
    assign bus.multi_err = r_multi_err;
    assign bus.stable    = r_stable;

endmodule
